// File: rtl/ifetch_axi_bridge.sv
// Fetch-side responder: turns one held fetch request into a single-beat AXI4 read and
// returns the instruction with a one-cycle ready pulse; a flush discards the in-flight result.
module ifetch_axi_bridge #(
  parameter logic [3:0]  ID          = 4'd0,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_flush,
  output logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic        fetch_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state, stateNext;
  logic [31:2] addrQ;
  logic        discardQ;
  logic [31:0] instrQ;
  logic        errQ;
  logic        acceptReq, captureResp, dropResp;
  logic        unusedRlast;

  // A single beat is always the last one, so rlast carries no information here.
  assign unusedRlast = rlast;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    stateNext   = state;
    acceptReq   = 1'b0;
    captureResp = 1'b0;
    dropResp    = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req && !fetch_flush) begin
          acceptReq = 1'b1;
          stateNext = ADDR;
        end
      end
      ADDR: begin
        if (arready) stateNext = DATA;
      end
      DATA: begin
        if (rvalid) begin
          // A flush arriving with the data beat still wins: the beat is dropped.
          if (discardQ || fetch_flush) begin
            dropResp  = 1'b1;
            stateNext = IDLE;
          end else begin
            captureResp = 1'b1;
            stateNext   = RESP;
          end
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addrQ    <= '0;
      discardQ <= 1'b0;
      instrQ   <= RESET_INSTR;
      errQ     <= 1'b0;
    end else begin
      state <= stateNext;
      if (acceptReq) addrQ <= fetch_addr[31:2];
      if (dropResp)
        discardQ <= 1'b0;
      else if (fetch_flush && (state == ADDR || state == DATA))
        discardQ <= 1'b1;
      if (captureResp) begin
        instrQ <= (rresp == 2'b00) ? rdata : RESET_INSTR;
        errQ   <= (rresp != 2'b00);
      end
    end
  end

  assign arid        = ID;
  assign araddr      = {addrQ, 2'b00};
  assign arlen       = 8'd0;
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
  assign arvalid     = (state == ADDR);
  assign rready      = (state == DATA);
  assign fetch_ready = (state == RESP);
  assign fetch_instr = instrQ;
  assign fetch_err   = errQ & (state == RESP);

endmodule

// File: tb/tb_ifetch_axi_bridge.sv
// Randomized bench for ifetch_axi_bridge: the bench plays requester and AXI slave and
// predicts each fetch outcome from address alignment, response code and flush timing.
module tb_ifetch_axi_bridge;

  localparam logic [31:0] RESET_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_flush, fetch_ready, fetch_err;
  logic [31:0] fetch_addr, fetch_instr;
  logic [3:0]  arid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] lastInstr;

  ifetch_axi_bridge #(.ID(4'd0), .RESET_INSTR(RESET_INSTR)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_ready(fetch_ready), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flushPhase: 0 none, 1 in ADDR, 2 early in DATA, 3 with rvalid, 4 in RESP, 5 in IDLE at request.
  task automatic fetchTxn(input logic [31:0] addr, input int arWait, input int rWait,
                          input logic [31:0] data, input logic [1:0] resp, input int flushPhase);
    logic [31:0] expAraddr;
    logic [31:0] expInstr;
    logic        expErr;
    bit          dropped;
    expAraddr = addr & 32'hFFFF_FFFC;
    expInstr  = (resp == 2'b00) ? data : RESET_INSTR;
    expErr    = (resp != 2'b00);
    dropped   = (flushPhase >= 1 && flushPhase <= 3);

    fetch_req  = 1'b1;
    fetch_addr = addr;
    if (flushPhase == 5) begin
      fetch_flush = 1'b1;
      step();
      check("idle_flush_blocks", {31'd0, arvalid}, 32'd0);
      fetch_flush = 1'b0;
    end
    step();

    check("ar_consts", {15'd0, arid, arlen, arsize, arburst}, {15'd0, 4'd0, 8'd0, 3'b010, 2'b01});
    for (int k = 0; k <= arWait; k++) begin
      check("arvalid_held", {31'd0, arvalid}, 32'd1);
      check("araddr", araddr, expAraddr);
      check("rready_in_addr", {31'd0, rready}, 32'd0);
      arready     = (k == arWait);
      fetch_flush = (flushPhase == 1 && k == 0);
      if (fetch_flush) fetch_req = 1'b0;
      fetch_addr  = $urandom;
      step();
    end
    arready     = 1'b0;
    fetch_flush = 1'b0;

    check("arvalid_dropped", {31'd0, arvalid}, 32'd0);
    for (int k = 0; k <= rWait; k++) begin
      check("rready_held", {31'd0, rready}, 32'd1);
      check("no_early_ready", {31'd0, fetch_ready}, 32'd0);
      rvalid      = (k == rWait);
      rlast       = rvalid;
      rdata       = (k == rWait) ? data : $urandom;
      rresp       = (k == rWait) ? resp : 2'($urandom);
      fetch_flush = (flushPhase == 2 && k == 0) || (flushPhase == 3 && k == rWait);
      if (fetch_flush) fetch_req = 1'b0;
      step();
    end
    rvalid      = 1'b0;
    rlast       = 1'b0;
    fetch_flush = 1'b0;

    if (!dropped) begin
      if (flushPhase == 4) fetch_flush = 1'b1;
      check("fetch_ready", {31'd0, fetch_ready}, 32'd1);
      check("fetch_instr", fetch_instr, expInstr);
      check("fetch_err", {31'd0, fetch_err}, {31'd0, expErr});
      lastInstr = expInstr;
      fetch_req = 1'b0;
      step();
      fetch_flush = 1'b0;
      check("ready_one_cycle", {31'd0, fetch_ready}, 32'd0);
      check("idle_after_resp", {30'd0, arvalid, rready}, 32'd0);
    end else begin
      check("discard_no_ready", {31'd0, fetch_ready}, 32'd0);
      check("discard_to_idle", {30'd0, arvalid, rready}, 32'd0);
      check("discard_instr_held", fetch_instr, lastInstr);
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
    step();
    step();
    rst = 1'b0;
    check("rst_axi", {30'd0, arvalid, rready}, 32'd0);
    check("rst_ready", {31'd0, fetch_ready}, 32'd0);
    check("rst_instr", fetch_instr, RESET_INSTR);
    lastInstr = RESET_INSTR;

    fetchTxn(32'hBFC0_0000, 0, 0, 32'h3C08_BFC0, 2'b00, 0);
    fetchTxn(32'hBFC0_0004, 5, 0, 32'h2408_0001, 2'b00, 0);
    fetchTxn(32'hBFC0_0008, 0, 0, 32'hDEAD_BEEF, 2'b10, 0);
    fetchTxn(32'hBFC0_000C, 0, 3, 32'h1234_5678, 2'b00, 2);
    fetchTxn(32'hBFC0_0010, 0, 1, 32'hAABB_CCDD, 2'b00, 0);
    fetchTxn(32'hBFC0_0006, 1, 0, 32'h0000_0006, 2'b00, 0);
    fetchTxn(32'hBFC0_0014, 2, 1, 32'h5555_AAAA, 2'b00, 1);
    fetchTxn(32'hBFC0_0018, 0, 2, 32'h6666_7777, 2'b00, 3);
    fetchTxn(32'hBFC0_001C, 0, 0, 32'h8888_9999, 2'b00, 4);
    fetchTxn(32'hBFC0_0020, 0, 0, 32'hABCD_0123, 2'b11, 5);

    // Reset while waiting in DATA abandons the fetch.
    fetch_req  = 1'b1;
    fetch_addr = 32'hBFC0_0024;
    step();
    arready = 1'b1;
    step();
    arready   = 1'b0;
    fetch_req = 1'b0;
    check("pre_rst_data", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_axi", {30'd0, arvalid, rready}, 32'd0);
    check("mid_rst_ready", {31'd0, fetch_ready}, 32'd0);
    check("mid_rst_instr", fetch_instr, RESET_INSTR);
    lastInstr = RESET_INSTR;
    fetchTxn(32'hBFC0_0028, 0, 0, 32'h0BAD_F00D, 2'b00, 0);

    for (int i = 0; i < 150; i++) begin
      fetchTxn($urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
               $urandom, 2'($urandom), int'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
